// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM states and datapath select encodings
// shared by the main control FSM and the ALU decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_FUNC = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_BR  = 2'd1,
    PC_REG = 2'd2
  } pc_src_e;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_XOR  = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_JR   = 5'b00110;
  localparam logic [4:0] OP_ANDI = 5'b00111;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_LW   = 5'b01001;
  localparam logic [4:0] OP_SW   = 5'b01011;
  localparam logic [4:0] OP_BEQ  = 5'b01100;
  localparam logic [4:0] OP_LUI  = 5'b01110;

  // Register/ALU group occupies the low contiguous range.
  function automatic logic op_legal(input logic [4:0] op);
    return (op <= OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_LUI);
  endfunction

  function automatic logic op_imm(input logic [4:0] op);
    return (op == OP_ANDI) || (op == OP_ADDI) ||
           (op == OP_LW) || (op == OP_SW) ||
           (op == OP_LUI);
  endfunction

endpackage

// File: rtl/main_ctrl_fsm_if.sv
// main_ctrl_fsm_if: memory request/ready handshake
// between the control FSM (master) and memory (slave).
interface main_ctrl_fsm_if;

  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );

endinterface

// File: rtl/main_ctrl_fsm.sv
// main_ctrl_fsm: multi-cycle CPU control FSM.
// MAIN_CTRL_RETIRE_CNT_EN enables the retired-instruction counter.
module main_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [4:0]       opcode,
  input  logic             zero,
  main_ctrl_fsm_if.master  mem,
  output logic [1:0]       alu_op,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_imm,
  output logic             mem_to_reg,
  output logic [2:0]       state_o,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e  state_q, state_d;
  logic    illegal_q, illegal_d;
  logic    retire;
  logic    is_ls, is_br;
  logic    mem_req, mem_we;
  alu_op_e alu_op_c;
  pc_src_e pc_src_c;

  assign is_ls = (opcode == OP_LW) ||
                 (opcode == OP_SW);
  assign is_br = (opcode == OP_BEQ) ||
                 (opcode == OP_JR) ||
                 (opcode == OP_CMP);

  // Next state and retire event
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (run && mem.mem_ready)
          state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = op_legal(opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_ls: state_d = S_MEM;
          is_br: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem.mem_ready) begin
          if (opcode == OP_SW) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // State and sticky trap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes decoded from state; forced low while reset is held
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_imm = 1'b0;
    mem_to_reg  = 1'b0;
    alu_op_c    = ALU_ADD;
    pc_src_c    = PC_INC;
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          if (run) begin
            mem_req = 1'b1;
            if (mem.mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
            end
          end
        end
        S_EXEC: begin
          unique case (1'b1)
            is_ls:               alu_op_c = ALU_ADD;
            (opcode == OP_BEQ):  alu_op_c = ALU_SUB;
            default:             alu_op_c = ALU_FUNC;
          endcase
          alu_src_imm = op_imm(opcode);
          if (opcode == OP_BEQ && zero) begin
            pc_write = 1'b1;
            pc_src_c = PC_BR;
          end
          if (opcode == OP_JR) begin
            pc_write = 1'b1;
            pc_src_c = PC_REG;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (opcode == OP_SW);
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (opcode == OP_LW);
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req = mem_req;
  assign mem.mem_we  = mem_we;
  assign alu_op      = alu_op_c;
  assign pc_src      = pc_src_c;
  assign state_o     = state_q;
  assign illegal     = illegal_q;

`ifdef MAIN_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  // Wrapping count of completed instructions
  always_comb begin
    retired_d = retired_q;
    if (retire)
      retired_d = retired_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired_q <= '0;
    else
      retired_q <= retired_d;
  end

  assign retired = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign retired = '0;
`endif

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// tb_main_ctrl_fsm: instruction-level reference model,
// directed plus randomized instruction stream.
module tb_main_ctrl_fsm;
  import cpu_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         run;
  logic [4:0]   opcode;
  logic         zero;
  logic [1:0]   alu_op;
  logic         ir_write, pc_write, reg_write;
  logic [1:0]   pc_src;
  logic         alu_src_imm, mem_to_reg;
  logic [2:0]   state_o;
  logic         illegal;
  logic [W-1:0] retired;

  main_ctrl_fsm_if mif ();

  main_ctrl_fsm #(.CNT_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .opcode      (opcode),
    .zero        (zero),
    .mem         (mif),
    .alu_op      (alu_op),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .pc_src      (pc_src),
    .alu_src_imm (alu_src_imm),
    .mem_to_reg  (mem_to_reg),
    .state_o     (state_o),
    .illegal     (illegal),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       ill;
    logic       req;
    logic       we;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic [1:0] pcs;
    logic [1:0] alu;
    logic       imm;
    logic       m2r;
  } obs_t;

  int          n_chk  = 0;
  int          n_pass = 0;
  int unsigned exp_ret = 0;

  logic [4:0] legal_ops [13] = '{
    5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
    5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
    5'b01011, 5'b01100, 5'b01110
  };

  function automatic obs_t sample();
    obs_t o;
    o.st  = state_o;
    o.ill = illegal;
    o.req = mif.mem_req;
    o.we  = mif.mem_we;
    o.irw = ir_write;
    o.pcw = pc_write;
    o.rw  = reg_write;
    o.pcs = pc_src;
    o.alu = alu_op;
    o.imm = alu_src_imm;
    o.m2r = mem_to_reg;
    return o;
  endfunction

  function automatic logic [W-1:0] ret_exp();
`ifdef MAIN_CTRL_RETIRE_CNT_EN
    return W'(exp_ret);
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string tag, input obs_t e);
    obs_t o;
    o = sample();
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s outputs obs=%h exp=%h", tag, o, e);
    n_chk++;
    assert (retired === ret_exp()) n_pass++;
    else $error("FAIL %s retired obs=%0d exp=%0d",
                tag, retired, ret_exp());
  endtask

  task automatic cyc(input string tag, input obs_t e);
    @(negedge clk);
    chk(tag, e);
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t st_only(input logic [2:0] s);
    obs_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      run = 1'b0;
      mif.mem_ready = 1'($urandom);
      opcode = 5'($urandom);
      cyc("idle", st_only(S_FETCH));
    end
  endtask

  task automatic do_reset(input string tag);
    obs_t e;
    rst_n = 1'b0;
    run = 1'b1;
    mif.mem_ready = 1'b1;
    exp_ret = 0;
    #2;
    e = st_only(S_FETCH);
    chk(tag, e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mif.mem_ready = 1'b0;
  endtask

  // Expand one instruction into its expected cycle sequence.
  task automatic instr(input logic [4:0] op,
                       input logic z,
                       input int fw,
                       input int mw,
                       input bit rst_mid_mem);
    obs_t e;
    bit ls, lw, sw, beq, jr, cmp, legal;
    lw  = (op == 5'b01001);
    sw  = (op == 5'b01011);
    beq = (op == 5'b01100);
    jr  = (op == 5'b00110);
    cmp = (op == 5'b00101);
    ls  = lw || sw;
    legal = 1'b0;
    foreach (legal_ops[i])
      if (legal_ops[i] == op) legal = 1'b1;

    run = 1'b1;
    for (int i = 0; i < fw; i++) begin
      mif.mem_ready = 1'b0;
      opcode = 5'($urandom);
      e = st_only(S_FETCH);
      e.req = 1'b1;
      cyc("fetch_wait", e);
    end
    mif.mem_ready = 1'b1;
    e = st_only(S_FETCH);
    e.req = 1'b1;
    e.irw = 1'b1;
    e.pcw = 1'b1;
    cyc("fetch", e);

    opcode = op;
    run = 1'($urandom);
    zero = 1'($urandom);
    mif.mem_ready = 1'($urandom);
    cyc("decode", st_only(S_DECODE));

    if (!legal) begin
      for (int i = 0; i < 10; i++) begin
        run = 1'b1;
        mif.mem_ready = 1'($urandom);
        e = st_only(S_TRAP);
        e.ill = 1'b1;
        cyc("trap", e);
      end
      return;
    end

    zero = z;
    mif.mem_ready = 1'($urandom);
    e = st_only(S_EXEC);
    e.alu = ls ? 2'd0 : (beq ? 2'd1 : 2'd2);
    e.imm = ls || op == 5'b00111 ||
            op == 5'b01000 || op == 5'b01110;
    if (beq && z) begin
      e.pcw = 1'b1;
      e.pcs = 2'd1;
    end
    if (jr) begin
      e.pcw = 1'b1;
      e.pcs = 2'd2;
    end
    cyc("exec", e);
    zero = 1'($urandom);

    if (ls) begin
      for (int i = 0; i < mw; i++) begin
        if (rst_mid_mem && i == 1) begin
          do_reset("rst_mid_mem");
          return;
        end
        mif.mem_ready = 1'b0;
        e = st_only(S_MEM);
        e.req = 1'b1;
        e.we = sw;
        cyc("mem_wait", e);
      end
      mif.mem_ready = 1'b1;
      e = st_only(S_MEM);
      e.req = 1'b1;
      e.we = sw;
      cyc("mem", e);
    end

    if (!(beq || jr || cmp || sw)) begin
      mif.mem_ready = 1'($urandom);
      e = st_only(S_WB);
      e.rw = 1'b1;
      e.m2r = lw;
      cyc("wb", e);
    end
    exp_ret++;
  endtask

  initial begin
    obs_t e;
    rst_n = 1'b0;
    run = 1'b0;
    opcode = 5'd0;
    zero = 1'b0;
    mif.mem_ready = 1'b0;
    #2;
    chk("reset", st_only(S_FETCH));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    idle(2);
    instr(5'b00011, 1'b0, 1, 0, 1'b0);
    instr(5'b01100, 1'b1, 0, 0, 1'b0);
    instr(5'b01100, 1'b0, 0, 0, 1'b0);
    instr(5'b00110, 1'b0, 0, 0, 1'b0);
    instr(5'b00101, 1'b1, 0, 0, 1'b0);
    instr(5'b01001, 1'b0, 1, 3, 1'b0);
    instr(5'b01011, 1'b0, 0, 1, 1'b0);
    instr(5'b01110, 1'b0, 0, 0, 1'b0);
    instr(5'b00111, 1'b0, 2, 0, 1'b0);
    idle(1);

    for (int k = 0; k < 40; k++) begin
      idle(int'($urandom_range(0, 2)));
      instr(legal_ops[$urandom_range(0, 12)],
            1'($urandom),
            int'($urandom_range(0, 2)),
            int'($urandom_range(0, 3)),
            1'b0);
    end

    instr(5'b01011, 1'b0, 0, 3, 1'b1);
    e = st_only(S_FETCH);
    e.req = 1'b1;
    run = 1'b1;
    mif.mem_ready = 1'b0;
    cyc("fetch_after_rst", e);
    instr(5'b00011, 1'b0, 0, 0, 1'b0);

    instr(5'b11111, 1'b0, 0, 0, 1'b0);
    do_reset("rst_clear_trap");
    instr(5'b01000, 1'b0, 0, 0, 1'b0);
    instr(5'b01010, 1'b0, 1, 0, 1'b0);
    do_reset("rst_clear_trap2");
    instr(5'b00100, 1'b0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/main_ctrl_fsm.md
MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 run  input  1  when 0 in FETCH, no new fetch starts.
REQ-005 opcode  input  5  instruction register opcode field, valid from DECODE onward.
REQ-006 zero  input  1  ALU zero flag, sampled in EXEC.
REQ-007 mem_ready  input  1  memory completion strobe for the current request.
REQ-008 alu_op  output  2  to ALU decoder: 0=add, 1=sub, 2=decode-by-opcode.
REQ-009 mem_req  output  1  memory request, held until mem_ready.
REQ-010 mem_we  output  1  write qualifier for mem_req.
REQ-011 ir_write, pc_write, reg_write  output  1 each  load strobes.
REQ-012 pc_src  output  2  0=PC+1, 1=branch target, 2=register (JR).
REQ-013 alu_src_imm, mem_to_reg  output  1 each  datapath muxes.
REQ-014 state_o  output  3  current state encoding; illegal  output  1  sticky trap flag.
REQ-015 retired  output  CNT_W  retired-instruction count.

Function
REQ-016 States SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP; outputs Moore-decoded from the state register plus opcode/zero/mem_ready where stated.
REQ-017 FETCH: while run=1 assert mem_req, mem_we=0; on mem_ready pulse ir_write and pc_write (pc_src=0) and go to DECODE; run=0 holds FETCH with mem_req=0.
REQ-018 DECODE (1 cycle): legal opcodes 00000-01000, 01001 LW, 01011 SW, 01100 BEQ, 01110 LUI go to EXEC; any other opcode goes to TRAP.
REQ-019 EXEC (1 cycle): alu_op=0 for LW/SW, 1 for BEQ, 2 otherwise; alu_src_imm=1 for ANDI, ADDI, LW, SW, LUI.
REQ-020 EXEC exit: LW/SW to MEM; BEQ to FETCH with pc_write=1, pc_src=1 iff zero=1; JR (00110) to FETCH with pc_write=1, pc_src=2; CMP (00101) to FETCH with no write; others to WB.
REQ-021 MEM: mem_req=1, mem_we=1 for SW; on mem_ready SW goes to FETCH, LW goes to WB; no timeout.
REQ-022 WB (1 cycle): reg_write=1, mem_to_reg=1 for LW only; then FETCH.
REQ-023 TRAP: all strobes 0, illegal=1, remain until reset.
REQ-024 Latency excluding memory waits: ALU ops 4 cycles, LW 5, SW 4, BEQ/JR/CMP 3.
REQ-025 mem_ready outside FETCH/MEM SHALL be ignored; mem_req SHALL not deassert before mem_ready.

Reset
REQ-026 rst_n=0 SHALL immediately force FETCH, illegal=0, retired=0, all strobes 0, mid-operation included; first request issues the first clk after release with run=1.

Configuration
REQ-027 Macro MAIN_CTRL_RETIRE_CNT_EN defined: retired increments by 1 on each transition into FETCH from EXEC, MEM or WB, wrapping modulo 2^CNT_W.
REQ-028 Macro undefined: retired tied to 0, no counter flops.

Structure
REQ-029 Package cpu_pkg SHALL hold the opcode localparams, state enum, alu_op and pc_src encodings, shared with the ALU decoder.
REQ-030 No sub-module; a single FSM with next-state and output always blocks.

Verification
REQ-031 ADD (00011), mem_ready 1 cycle after each request -> ir_write cycle 1, alu_op=2 in EXEC, reg_write in WB, retired=1.
REQ-032 BEQ with zero=1 -> EXEC pc_write=1, pc_src=1, no reg_write; zero=0 -> pc_write=0.
REQ-033 LW with mem_ready delayed 3 cycles -> mem_req held 4 cycles in MEM, WB mem_to_reg=1, reg_write=1.
REQ-034 Opcode 11111 -> TRAP, illegal=1 held 10 cycles, mem_req=0; rst_n pulse clears it.
REQ-035 rst_n low during MEM of SW -> outputs 0 same cycle, FETCH after release; retired 16'hFFFF +1 -> 0.
